// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared encodings for the calculator arithmetic datapath:
//            control-state codes, operation codes, internal FSM states and
//            default sizing.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

   // Control-state codes driven by the upstream calculator FSM
   localparam logic [1:0] ST_RST = 2'b00;
   localparam logic [1:0] ST_A   = 2'b01;
   localparam logic [1:0] ST_B   = 2'b10;
   localparam logic [1:0] ST_R   = 2'b11;

   // Operation codes; 101..111 are illegal
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_SQRT = 3'b100;

   // Datapath sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } calc_state_e;

   localparam int DEF_W          = 16;
   localparam int DEF_MAX_DIGITS = 4;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : calc_iter_unit
// Purpose  : Iterative engine shared by multiply (shift-add), divide
//            (restoring) and square root (digit-by-digit). One iteration per
//            clock; done is asserted once all iterations have been applied.
//            Non-iterative opcodes simply run a single empty iteration so the
//            caller sees a uniform handshake.
// Revision : 1.0 - initial release
// ============================================================================
module calc_iter_unit
   import calc_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] q,
   output logic         ovf,
   output logic         dz
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // acc: product / partial remainder; sh: multiplicand / divisor / root;
   // aux: multiplier / dividend-quotient / radicand shift register
   logic            busy_q, busy_d;
   logic [CW-1:0]   cnt_q,  cnt_d;
   logic [2:0]      op_q,   op_d;
   logic [2*W-1:0]  acc_q,  acc_d;
   logic [2*W-1:0]  sh_q,   sh_d;
   logic [W-1:0]    aux_q,  aux_d;
   logic            dz_q,   dz_d;

   logic [W:0]      div_r;
   logic [2*W-1:0]  sq_rem;
   logic [2*W-1:0]  sq_trial;

   // Load operands on start, then apply one iteration of the latched op per cycle
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      sh_d     = sh_q;
      aux_d    = aux_q;
      dz_d     = dz_q;
      div_r    = {acc_q[W-1:0], aux_q[W-1]};
      sq_rem   = {acc_q[2*W-3:0], aux_q[W-1:W-2]};
      sq_trial = {sh_q[2*W-3:0], 2'b01};

      if (abort) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         busy_d = 1'b1;
         op_d   = op;
         dz_d   = (op == OP_DIV) && (b == '0);
         acc_d  = '0;
         sh_d   = '0;
         aux_d  = '0;
         case (op)
            OP_MUL: begin
               sh_d  = {{W{1'b0}}, a};
               aux_d = b;
               cnt_d = CW'(W);
            end
            OP_DIV: begin
               sh_d  = {{W{1'b0}}, b};
               aux_d = a;
               cnt_d = CW'(W);
            end
            OP_SQRT: begin
               aux_d = a;
               cnt_d = CW'(W / 2);
            end
            default: cnt_d = CNT_ONE;
         endcase
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
            case (op_q)
               OP_MUL: begin
                  if (aux_q[0]) acc_d = acc_q + sh_q;
                  sh_d  = sh_q << 1;
                  aux_d = aux_q >> 1;
               end
               OP_DIV: begin
                  if (div_r >= {1'b0, sh_q[W-1:0]}) begin
                     acc_d = {{(W-1){1'b0}}, div_r - {1'b0, sh_q[W-1:0]}};
                     aux_d = {aux_q[W-2:0], 1'b1};
                  end else begin
                     acc_d = {{(W-1){1'b0}}, div_r};
                     aux_d = {aux_q[W-2:0], 1'b0};
                  end
               end
               OP_SQRT: begin
                  if (sq_rem >= sq_trial) begin
                     acc_d = sq_rem - sq_trial;
                     sh_d  = {sh_q[2*W-2:0], 1'b1};
                  end else begin
                     acc_d = sq_rem;
                     sh_d  = {sh_q[2*W-2:0], 1'b0};
                  end
                  aux_d = {aux_q[W-3:0], 2'b00};
               end
               default: ;
            endcase
         end else begin
            busy_d = 1'b0;
         end
      end
   end

   // Iteration state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         op_q   <= OP_ADD;
         acc_q  <= '0;
         sh_q   <= '0;
         aux_q  <= '0;
         dz_q   <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         acc_q  <= acc_d;
         sh_q   <= sh_d;
         aux_q  <= aux_d;
         dz_q   <= dz_d;
      end
   end

   // Result selection for the latched op
   always_comb begin
      q = '0;
      case (op_q)
         OP_MUL:  q = acc_q[W-1:0];
         OP_DIV:  q = aux_q;
         OP_SQRT: q = sh_q[W-1:0];
         default: q = '0;
      endcase
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == '0);
   assign ovf  = (op_q == OP_MUL) && (|acc_q[2*W-1:W]);
   assign dz   = dz_q;

endmodule : calc_iter_unit
`default_nettype wire

// File: rtl/calc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : calc_datapath
// Purpose  : Calculator arithmetic datapath. Accumulates decimal operands A
//            and B from key presses, launches the selected operation when the
//            control state enters R, and holds the registered result until
//            the control state leaves R.
// Revision : 1.0 - initial release
// ============================================================================
module calc_datapath
   import calc_pkg::*;
#(
   parameter int W          = DEF_W,
   parameter int MAX_DIGITS = DEF_MAX_DIGITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   estado,
   input  logic [2:0]   OP,
   input  logic         digit_valid,
   input  logic [3:0]   digit,
   output logic [W-1:0] op_a,
   output logic [W-1:0] op_b,
   output logic [W-1:0] result,
   output logic         neg,
   output logic         err,
   output logic         busy,
   output logic         done
);

   localparam int CNTW = $clog2(MAX_DIGITS + 1);
   localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_DIGITS);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   calc_state_e      state_q, state_d;
   logic [1:0]       estado_q, estado_d;
   logic [2:0]       op_l_q, op_l_d;
   logic [W-1:0]     op_a_q, op_a_d;
   logic [W-1:0]     op_b_q, op_b_d;
   logic [CNTW-1:0]  cnt_a_q, cnt_a_d;
   logic [CNTW-1:0]  cnt_b_q, cnt_b_d;
   logic [W-1:0]     result_q, result_d;
   logic             neg_q, neg_d;
   logic             err_q, err_d;

   logic             start;
   logic             iter_abort;
   logic             iter_busy;
   logic             iter_done;
   logic [W-1:0]     iter_q;
   logic             iter_ovf;
   logic             iter_dz;
   logic [W:0]       sum;
   logic [W-1:0]     digit_ext;

   // Launch only on the entry into R, so a held R never retriggers
   assign start      = (estado == ST_R) && (estado_q != ST_R) && (state_q == IDLE);
   assign iter_abort = (state_q != IDLE) && (estado != ST_R);
   assign sum        = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign digit_ext  = {{(W-4){1'b0}}, digit};

   calc_iter_unit #(
      .W (W)
   ) u_iter (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .abort (iter_abort),
      .op    (OP),
      .a     (op_a_q),
      .b     (op_b_q),
      .busy  (iter_busy),
      .done  (iter_done),
      .q     (iter_q),
      .ovf   (iter_ovf),
      .dz    (iter_dz)
   );

   // Operand entry, start/abort sequencing and result capture
   always_comb begin
      state_d  = state_q;
      estado_d = estado;
      op_l_d   = op_l_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      cnt_a_d  = cnt_a_q;
      cnt_b_d  = cnt_b_q;
      result_d = result_q;
      neg_d    = neg_q;
      err_d    = err_q;

      if (estado == ST_RST) begin
         state_d  = IDLE;
         op_l_d   = OP_ADD;
         op_a_d   = '0;
         op_b_d   = '0;
         cnt_a_d  = '0;
         cnt_b_d  = '0;
         result_d = '0;
         neg_d    = 1'b0;
         err_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_l_d   = OP;
                  state_d  = CALC;
                  result_d = '0;
                  neg_d    = 1'b0;
                  err_d    = 1'b0;
               end else if (digit_valid && (digit <= 4'd9)) begin
                  if ((estado == ST_A) && (cnt_a_q < MAX_CNT)) begin
                     op_a_d  = (op_a_q << 3) + (op_a_q << 1) + digit_ext;
                     cnt_a_d = cnt_a_q + CNT_ONE;
                  end else if ((estado == ST_B) && (cnt_b_q < MAX_CNT)) begin
                     op_b_d  = (op_b_q << 3) + (op_b_q << 1) + digit_ext;
                     cnt_b_d = cnt_b_q + CNT_ONE;
                  end
               end
            end
            CALC: begin
               if (estado != ST_R) begin
                  state_d  = IDLE;
                  result_d = '0;
                  neg_d    = 1'b0;
                  err_d    = 1'b0;
               end else if (iter_done) begin
                  state_d = DONE;
                  neg_d   = 1'b0;
                  err_d   = 1'b0;
                  case (op_l_q)
                     OP_ADD: begin
                        result_d = sum[W-1:0];
                        err_d    = sum[W];
                     end
                     OP_SUB: begin
                        if (op_a_q >= op_b_q) begin
                           result_d = op_a_q - op_b_q;
                        end else begin
                           result_d = op_b_q - op_a_q;
                           neg_d    = 1'b1;
                        end
                     end
                     OP_MUL: begin
                        result_d = iter_q;
                        err_d    = iter_ovf;
                     end
                     OP_DIV: begin
                        result_d = iter_dz ? '0 : iter_q;
                        err_d    = iter_dz;
                     end
                     OP_SQRT: result_d = iter_q;
                     default: begin
                        result_d = '0;
                        err_d    = 1'b1;
                     end
                  endcase
               end
            end
            DONE: begin
               if (estado != ST_R) begin
                  state_d  = IDLE;
                  result_d = '0;
                  neg_d    = 1'b0;
                  err_d    = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         estado_q <= ST_RST;
         op_l_q   <= OP_ADD;
         op_a_q   <= '0;
         op_b_q   <= '0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         estado_q <= estado_d;
         op_l_q   <= op_l_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
      end
   end

   assign op_a   = op_a_q;
   assign op_b   = op_b_q;
   assign result = result_q;
   assign neg    = neg_q;
   assign err    = err_q;
   assign busy   = iter_busy;
   assign done   = (state_q == DONE);

endmodule : calc_datapath
`default_nettype wire

// File: tb/tb_calc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_datapath
// Purpose  : Scoreboard bench for calc_datapath. Stimulus enters operands,
//            launches operations and queues the expected outcome computed by
//            a plain-arithmetic reference model; a monitor pops the queue on
//            each rising done and compares value, flags and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_datapath;
   import calc_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   estado;
   logic [2:0]   OP;
   logic         digit_valid;
   logic [3:0]   digit;
   logic [W-1:0] op_a, op_b, result;
   logic         neg, err, busy, done;

   calc_datapath #(.W(W), .MAX_DIGITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .estado      (estado),
      .OP          (OP),
      .digit_valid (digit_valid),
      .digit       (digit),
      .op_a        (op_a),
      .op_b        (op_b),
      .result      (result),
      .neg         (neg),
      .err         (err),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          res;
      int          neg;
      int          err;
      int unsigned due;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference operand state, following the key-entry rules
   int ma, mb, ma_cnt, mb_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model(input int a, input int b, input int op,
                                 output int res, output int ng, output int er, output int n);
      int s;
      res = 0; ng = 0; er = 0; n = 1;
      case (op)
         0: begin s = a + b; res = s % 65536; er = (s > 65535); n = 1; end
         1: begin
            if (a >= b) res = a - b; else begin res = b - a; ng = 1; end
            n = 1;
         end
         2: begin s = a * b; res = s % 65536; er = (s > 65535); n = W; end
         3: begin
            if (b == 0) begin res = 0; er = 1; end else res = a / b;
            n = W;
         end
         4: begin
            s = 0;
            while ((s + 1) * (s + 1) <= a) s++;
            res = s; n = W / 2;
         end
         default: begin res = 0; er = 1; n = 1; end
      endcase
   endfunction

   task automatic clear_model;
      ma = 0; mb = 0; ma_cnt = 0; mb_cnt = 0;
   endtask

   task automatic press(input int d);
      @(negedge clk);
      digit       = d[3:0];
      digit_valid = 1'b1;
      if (d <= 9) begin
         if (estado == ST_A && ma_cnt < 4) begin ma = ma * 10 + d; ma_cnt++; end
         if (estado == ST_B && mb_cnt < 4) begin mb = mb * 10 + d; mb_cnt++; end
      end
      @(negedge clk);
      digit_valid = 1'b0;
   endtask

   task automatic enter_num(input int v);
      int digs[$];
      if (v == 0) digs.push_back(0);
      while (v > 0) begin
         digs.push_front(v % 10);
         v = v / 10;
      end
      foreach (digs[i]) press(digs[i]);
   endtask

   task automatic load(input int a, input int b);
      @(negedge clk);
      estado = ST_RST;
      clear_model();
      @(negedge clk);
      estado = ST_A;
      enter_num(a);
      @(negedge clk);
      estado = ST_B;
      enter_num(b);
      @(negedge clk);
      check("op_a after entry", op_a, ma);
      check("op_b after entry", op_b, mb);
   endtask

   task automatic start_op(input int op);
      @(negedge clk);
      OP     = op[2:0];
      estado = ST_R;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int op, input string tag);
      exp_t e;
      int   n;
      bit   got;
      model(ma, mb, op, e.res, e.neg, e.err, n);
      start_op(op);
      e.due = cyc + n + 1;
      e.tag = tag;
      sb.push_back(e);
      check({tag, " busy after start"}, busy, 1);
      @(negedge clk);
      OP = 3'($urandom_range(0, 7));
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      if (!got) begin
         check({tag, " done timeout"}, 0, 1);
         if (sb.size() > 0) void'(sb.pop_back());
      end else begin
         repeat (2) @(negedge clk);
         check({tag, " done held"}, done, 1);
         check({tag, " result held"}, result, e.res);
      end
      estado = ST_A;
      @(negedge clk);
      check({tag, " done cleared on leave"}, done, 0);
      check({tag, " result cleared on leave"}, {result, err, neg}, 0);
   endtask

   // Monitor: compare each completed operation against the oldest expectation
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (sb.size() == 0) begin
            check("unexpected done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.tag, " result"}, result, mon_e.res);
            check({mon_e.tag, " neg"}, neg, mon_e.neg);
            check({mon_e.tag, " err"}, err, mon_e.err);
            check({mon_e.tag, " latency"}, cyc, mon_e.due);
            check({mon_e.tag, " busy at done"}, busy, 0);
         end
      end
      done_prev <= done;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, op;
      rst = 1'b1; estado = ST_RST; OP = 3'd0; digit_valid = 1'b0; digit = 4'd0;
      clear_model();
      repeat (2) @(negedge clk);
      check("reset op_a", op_a, 0);
      check("reset op_b", op_b, 0);
      check("reset result", result, 0);
      check("reset flags", {neg, err, busy, done}, 0);
      rst = 1'b0;

      load(12, 34);   run_op(0, "add 12+34");
      load(5, 9);     run_op(1, "sub 5-9");
      load(9, 5);     run_op(1, "sub 9-5");
      load(300, 300); run_op(2, "mul 300*300");
      load(99, 99);   run_op(2, "mul 99*99");
      load(100, 7);   run_op(3, "div 100/7");
      load(100, 0);   run_op(3, "div by zero");
      load(99, 0);    run_op(4, "sqrt 99");
      load(9999, 9999); run_op(0, "add max");
      load(9999, 0);  run_op(4, "sqrt 9999");

      // Fifth key and out-of-range key are ignored
      @(negedge clk); estado = ST_RST; clear_model();
      @(negedge clk); estado = ST_A;
      press(1); press(2); press(3); press(4); press(5); press(12);
      @(negedge clk);
      check("op_a five keys", op_a, 1234);
      check("op_a model five keys", op_a, ma);

      // Abort via estado=RST mid-multiply
      load(300, 300);
      start_op(2);
      repeat (5) @(negedge clk);
      estado = ST_RST;
      clear_model();
      @(posedge clk); #1;
      check("abort rst busy/done", {busy, done}, 0);
      check("abort rst result", {result, neg, err}, 0);
      check("abort rst operands", {op_a, op_b}, 0);

      // Asynchronous reset mid-multiply, observed before the next clock edge
      load(300, 300);
      start_op(2);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst busy/done", {busy, done}, 0);
      check("async rst result", {result, neg, err}, 0);
      check("async rst operands", {op_a, op_b}, 0);
      @(negedge clk);
      estado = ST_RST;
      rst = 1'b0;
      clear_model();

      // Leaving R to A mid-divide keeps operands, then a fresh start works
      load(100, 7);
      start_op(3);
      repeat (4) @(negedge clk);
      estado = ST_A;
      @(negedge clk);
      check("abort to A busy/done", {busy, done}, 0);
      check("abort to A operands", {op_a, op_b}, {16'd100, 16'd7});
      run_op(3, "div after abort");
      run_op(6, "illegal op 110");

      for (int i = 0; i < 25; i++) begin
         a  = $urandom_range(0, 9999);
         b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 9999);
         op = $urandom_range(0, 7);
         load(a, b);
         run_op(op, $sformatf("rand%0d op%0d %0d,%0d", i, op, a, b));
      end

      repeat (5) @(negedge clk);
      check("scoreboard drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_calc_datapath
`default_nettype wire

// File: doc/calc_datapath.md
Name: calc_datapath

Overview:
Arithmetic datapath directly downstream of the calculator control FSM.
- Consumes the FSM's `estado` and `OP` outputs plus decoded digit-key presses.
- Accumulates decimal operands A and B, and runs the selected operation when `estado` enters R.
- Iterative multiply, divide and square-root units keep area small; results go to the display stage.

Parameters:
W, 16, operand/result width in bits (unsigned)
MAX_DIGITS, 4, maximum decimal digits accepted per operand (9999 max)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
estado  in  2  control state: 00 RST, 01 A, 10 B, 11 R
OP  in  3  operation: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt, others illegal
digit_valid  in  1  single-cycle pulse, digit key pressed
digit  in  4  key value, 0-9 legal
op_a  out  W  current operand A (for display)
op_b  out  W  current operand B (for display)
result  out  W  operation result
neg  out  1  result is negative (sub only)
err  out  1  overflow, divide-by-zero or illegal OP
busy  out  1  operation in progress
done  out  1  result valid, level, held until estado leaves R

Behaviour:
- Reset (rst=1 asynchronously, or estado==RST sampled on an edge):
  - All outputs 0; internal FSM to IDLE; digit counters to 0.
- Digit entry, estado==A and FSM IDLE:
  - digit_valid with digit<=9 and cnt_a<MAX_DIGITS -> op_a <= op_a*10+digit, cnt_a++.
  - digit>9 or cnt_a==MAX_DIGITS -> press ignored.
- Digit entry, estado==B: same rule into op_b / cnt_b.
- digit_valid is ignored when estado is R or RST.
- Start: estado_q registers estado each cycle. Edge where estado==R and estado_q!=R, with FSM in IDLE:
  - OP latched into op_l.
  - FSM IDLE->CALC; busy=1; iteration counter loaded with N.
  - N: add=1, sub=1, mul=W, div=W, sqrt=W/2, illegal=1.
- CALC: one iteration per cycle. On the last iteration the FSM goes to DONE: result/neg/err registered, busy=0, done=1.
  - done therefore rises N+1 edges after the start edge.
- Operation rules:
  - add: A+B, W bits; err if carry out.
  - sub: if A>=B then result=A-B, neg=0; else result=B-A, neg=1.
  - mul: shift-add over W cycles, 2W-bit product; result = low W bits; err if any high bit is set.
  - div: restoring division, quotient floor(A/B), W cycles, remainder discarded.
    - B==0 -> err=1, result=0; still N=W cycles, so latency is uniform.
  - sqrt: floor(sqrt(A)), digit-by-digit, W/2 cycles; B is ignored.
  - illegal OP (101-111): err=1, result=0.
- OP changes after the start edge are ignored; op_l is used throughout.
- DONE holds all outputs while estado==R.
- estado leaving R at any point (including mid-CALC): abort.
  - To RST: full clear as in reset.
  - To A or B (not produced by the FSM, but must be handled): FSM to IDLE, busy=done=0, result/neg/err=0, operands kept.
- A new start requires estado to leave R and re-enter it.
- rst asserted mid-CALC: immediate clear; no partial result is visible.

Decomposition:
- Package calc_pkg holds:
  - estado encodings ST_RST/ST_A/ST_B/ST_R.
  - OP codes OP_ADD/OP_SUB/OP_MUL/OP_DIV/OP_SQRT.
  - Internal FSM enum IDLE/CALC/DONE.
  - Default W and MAX_DIGITS.
- One sub-module, calc_iter_unit:
  - Contains the shared shift/accumulate registers for mul/div/sqrt.
  - Interface: start, op, a, b in; busy, done, q, ovf, dz out.
- calc_datapath keeps operand entry, add/sub, start detection and output registers.

Test Plan:
1. A keys 1,2; B keys 3,4; OP=000; estado->R -> op_a=12, op_b=34; busy for 1 cycle; done at start+2 with result=46, neg=0, err=0.
2. A=5, B=9, OP=001 -> result=4, neg=1, done at start+2; then A=9, B=5 -> result=4, neg=0.
3. A=300, B=300, OP=010 -> busy 16 cycles; result=24464 (90000 mod 65536), err=1. A=99, B=99 -> result=9801, err=0.
4. A=100, B=7, OP=011 -> result=14 after 16 busy cycles. B=0 -> result=0, err=1, same latency.
5. A=99, OP=100 -> result=9 after 8 busy cycles. A=10000 is unreachable: A keys 1,2,3,4,5 give op_a=1234, and the 5th key is ignored.
6. Abort and illegal OP:
   - Start mul, then set estado=RST at busy cycle 5 -> next edge busy=0, done=0, result=0, op_a=op_b=0.
   - Repeat with async rst pulse -> same clear, asserted without waiting for a clock edge.
   - OP=110 -> err=1, result=0, done at start+2.
